// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes and
// datapath select values.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StJal      = 4'd9;
  localparam state_t StBeq      = 4'd10;

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OpLw) || (op == OpSw) || (op == OpRType) || (op == OpIType) ||
           (op == OpJal) || (op == OpBeq);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format select; R-type and unknown opcodes fall back to
// the I format.
module imm_src_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  always_comb begin
    imm_src_o = ImmI;
    case (op_i)
      OpSw:    imm_src_o = ImmS;
      OpBeq:   imm_src_o = ImmB;
      OpJal:   imm_src_o = ImmJ;
      default: imm_src_o = ImmI;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control sequencer: walks each instruction through its
// datapath steps, stalling on the memory ready handshake.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_o
);

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                pc_update, branch, retire;

  imm_src_decoder u_imm_src_decoder (
    .op_i      (op),
    .imm_src_o (imm_src)
  );

  always_comb begin
    state_d    = StFetch;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRd2;
    reg_write  = 1'b0;
    alu_op     = AluOpAdd;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_d    = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExecR;
          OpIType:    state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
        state_d   = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = mem_ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      StMemWrite: begin
        // Strobe stays up across wait cycles; the store completes on mem_ready.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? StFetch : StMemWrite;
      end
      StExecR: begin
        alu_src_a = SrcARd1;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = SrcARd1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign pc_write  = pc_update | (branch & zero);
  assign retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
  assign retired   = retired_q;
  assign state_o   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle sequencer for the RV32I subset (lw, sw, R-type, I-type ALU, jal, beq).
- Consumes the opcode latched in the instruction register.
- Drives per-cycle datapath enables and select lines, plus ALUOp for the existing combinational ALU decoder.
- Sits between the instruction register and the datapath muxes/enables; stalls on a single-ported memory ready handshake.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode from instruction register; must be stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register enable = pc_update | (branch & zero).
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  instruction register / OldPC enable.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1.
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- imm_src  out  2  I 00, S 01, B 10, J 11; combinational from op; 00 for R-type/illegal.
- reg_write  out  1  register file write enable.
- alu_op  out  2  00 add, 01 subtract (beq), 10 funct-decoded.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- retired  out  RETIRE_W  count of completed instructions.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, active-high):
  - state = FETCH, retired = 0, illegal_op = 0.
  - All outputs take their FETCH values with mem_ready low.
- Outputs are Moore (state-derived), except:
  - ir_write, pc_update and mem_write are gated by mem_ready as noted below.
  - pc_write depends on zero.
- Defaults in every state: all enables = 0, selects = 00.
- FETCH
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (computes branch target; always one cycle)
  - alu_src_a=01, alu_src_b=01, alu_op=00.
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other value -> FETCH, with illegal_op=1 for exactly one cycle (the DECODE cycle); the instruction is not retired.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: result_src=00, adr_src=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1, then -> FETCH.
- MEMWRITE
  - result_src=00, adr_src=1, mem_write=1 held until the cycle mem_ready=1.
  - Then -> FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10, then -> ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10, then -> ALUWB.
- ALUWB: result_src=00, reg_write=1, then -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then -> ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, then -> FETCH.
- Retirement
  - retired += 1 on the clock edge leaving MEMWB, MEMWRITE (with mem_ready), ALUWB, or BEQ.
  - The counter wraps modulo 2^RETIRE_W.
- Instruction latencies in cycles, with zero memory wait:
  - lw 5, sw 4, R/I 4, jal 4, beq 3.
  - Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction: immediate return to FETCH, no write or retire completes, counter cleared.
- Unused state encodings: next state = FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10;
  - opcode constants;
  - the alu_op, result_src and alu_src encodings.
- One natural sub-module: imm_src_decoder, the combinational op -> imm_src mapping, shared with other users.
- The ALU decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset asserted mid-MEMREAD -> state_o=0 asynchronously, retired=0, reg_write=0; after release, FETCH issues adr_src=0.
- R-type (op=0110011), mem_ready tied 1 -> states 0,1,6,8,0; reg_write high only in the ALUWB cycle; retired 0->1 after 4 cycles.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; ir_write pulses once; reg_write=1 with result_src=01.
- sw with 1 wait cycle -> mem_write high for 2 consecutive cycles with adr_src=1; reg_write never asserted.
- beq with zero=1 -> pc_write=1 in the BEQ cycle; with zero=0 -> pc_write=0. Latency is 3 cycles in both cases.
- op=1111111 -> illegal_op pulses once in DECODE, then FETCH; retired unchanged; no reg_write or mem_write.
